ccff_loader: RTL
================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1024, giving the configuration chain length in bits (legal range 1..65535).
REQ-002 SHALL have parameter RST_CYCLES, default 4, giving the chain prog_reset pulse length in cycles (legal range 1..255).
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port prog_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a load when sampled high in IDLE or DONE.
REQ-006 SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-007 SHALL have port cfg_data, input, 32 bits: bitstream word, shifted out LSB first.
REQ-008 SHALL have ports cfg_valid (input) and cfg_ready (output), 1 bit each: word handshake; a word transfers on a cycle where both are high.
REQ-009 SHALL have port ccff_head_out, output, 1 bit: serial data to the chain ccff_head.
REQ-010 SHALL have port ccff_shift_en, output, 1 bit: chain clock enable; the chain advances one bit per cycle with this high.
REQ-011 SHALL have port ccff_tail_in, input, 1 bit: serial data from the chain ccff_tail.
REQ-012 SHALL have port prog_reset_out, output, 1 bit: active-high reset to the chain.
REQ-013 SHALL have port isol_n_out, output, 1 bit: fabric isolation, low while the fabric is unconfigured.
REQ-014 SHALL have ports busy and done, outputs, 1 bit each: status.
REQ-015 SHALL have ports rb_data (output, 32 bits) and rb_valid (output, 1 bit): readback stream.

Function
REQ-016 SHALL implement states IDLE, CHAIN_RST, SHIFT and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL transition to CHAIN_RST, clear the bit counter and drop done.
REQ-018 CHAIN_RST SHALL hold prog_reset_out=1 for exactly RST_CYCLES cycles, then transition to SHIFT.
REQ-019 In SHIFT, cfg_ready SHALL be high when the word register is empty, or when it holds one bit that is shifting this cycle, and CHAIN_LEN bits have not yet all been accepted; back-to-back words SHALL incur no bubble.
REQ-020 A word accepted in cycle N SHALL drive bit 0 on ccff_head_out with ccff_shift_en=1 in cycle N+1, then bits 1..31 on the following cycles.
REQ-021 With no word available, ccff_shift_en SHALL be 0 and ccff_head_out SHALL hold its last value.
REQ-022 Bits of the final word beyond CHAIN_LEN SHALL be discarded; the 16-bit bit counter SHALL never exceed CHAIN_LEN.
REQ-023 On the cycle after the CHAIN_LEN-th shift, the block SHALL enter DONE, set done=1 and isol_n_out=1.
REQ-024 isol_n_out SHALL be 0 in CHAIN_RST and SHIFT.
REQ-025 busy SHALL be 1 exactly in CHAIN_RST and SHIFT.
REQ-026 start while busy SHALL be ignored.
REQ-027 abort in CHAIN_RST or SHIFT SHALL return to IDLE next cycle with ccff_shift_en=0, isol_n_out=0 and done=0; the partial word SHALL be dropped.
REQ-028 abort and start in the same cycle SHALL resolve as abort.

Reset
REQ-029 prog_reset_n=0 SHALL immediately force IDLE and these output values: cfg_ready=0, ccff_head_out=0, ccff_shift_en=0, prog_reset_out=1, isol_n_out=0, busy=0, done=0, rb_valid=0, rb_data=0.
REQ-030 prog_reset_out SHALL fall to 0 on the first clock edge after prog_reset_n is released; a reset mid-load SHALL discard all progress.

Configuration
REQ-031 Macro CCFF_READBACK_EN SHALL compile readback in; without it, rb_data and rb_valid SHALL be tied to 0 and no readback registers SHALL exist.
REQ-032 With CCFF_READBACK_EN defined, each cycle with ccff_shift_en=1 SHALL capture ccff_tail_in into bit k of the readback word (k = captures since last emit), and rb_valid SHALL pulse for one cycle after every 32 captures.
REQ-033 With CCFF_READBACK_EN defined, a final partial readback word SHALL be emitted zero-padded in the cycle the block enters DONE; abort SHALL emit nothing.

Verification
REQ-034 CHAIN_LEN=64, RST_CYCLES=4: start, then 2 words with cfg_valid always 1 -> prog_reset_out high for 4 cycles; 64 consecutive ccff_shift_en cycles; done=1 and isol_n_out=1 one cycle after the last shift.
REQ-035 CHAIN_LEN=40: 2 words accepted -> exactly 40 shifts; cfg_ready stays 0 after the second word; bits 8..31 of word 2 never appear on ccff_head_out.
REQ-036 cfg_valid deasserted for 5 cycles mid-load -> ccff_shift_en=0 and ccff_head_out stable for those cycles; the total shift count is unchanged.
REQ-037 abort asserted after 10 shifts -> IDLE next cycle; busy=0, done=0, isol_n_out=0; a following start restarts from bit 0.
REQ-038 With CCFF_READBACK_EN defined, CHAIN_LEN=40, ccff_tail_in driven from a 40-bit delay model -> rb_valid pulses twice; rb_data word 2 bits 31..8 are 0.
REQ-039 prog_reset_n pulsed low mid-SHIFT -> all outputs take their REQ-029 values asynchronously; prog_reset_out falls on the first edge after release.

Source files
------------

// File: rtl/ccff_loader.sv
// Streams 32-bit bitstream words LSB-first into a configuration flip-flop chain (optional readback: CCFF_READBACK_EN).
// Latency: a word accepted in cycle N drives its bit 0 in cycle N+1; DONE follows the last shift by one cycle.
// Backpressure: cfg_ready only while the word register is empty or on its last bit; shifting stalls when no word is held.
module ccff_loader #(
    parameter int CHAIN_LEN  = 1024,
    parameter int RST_CYCLES = 4
) (
    input  logic        prog_clk,
    input  logic        prog_reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic        ccff_head_out,
    output logic        ccff_shift_en,
    input  logic        ccff_tail_in,
    output logic        prog_reset_out,
    output logic        isol_n_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] rb_data,
    output logic        rb_valid
);
    localparam logic [15:0] LEN  = 16'(CHAIN_LEN);
    localparam logic [7:0]  RLEN = 8'(RST_CYCLES);

    typedef enum logic [1:0] {IDLE, CHAIN_RST, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  rst_cnt_q;
    logic [15:0] bit_cnt_q;
    logic [15:0] acc_cnt_q;
    logic [31:0] wreg_q;
    logic [5:0]  wcnt_q;
    logic        rst_flag_q;

    logic        shifting, last_shift, start_ok, load;
    logic [15:0] remaining;
    logic [5:0]  load_bits;

    assign shifting   = (state_q == SHIFT) && (wcnt_q != 6'd0);
    assign last_shift = shifting && (bit_cnt_q == LEN - 16'd1);
    assign start_ok   = start && !abort && ((state_q == IDLE) || (state_q == DONE));
    assign busy       = (state_q == CHAIN_RST) || (state_q == SHIFT);
    // wcnt_q==1 in SHIFT always means that bit is leaving this cycle
    assign cfg_ready  = (state_q == SHIFT) && (acc_cnt_q < LEN) && (wcnt_q <= 6'd1);
    assign load       = cfg_valid && cfg_ready;
    assign remaining  = LEN - acc_cnt_q;
    assign load_bits  = (remaining >= 16'd32) ? 6'd32 : remaining[5:0];

    assign ccff_head_out  = wreg_q[0];
    assign ccff_shift_en  = shifting;
    assign prog_reset_out = rst_flag_q || (state_q == CHAIN_RST);
    assign isol_n_out     = (state_q == DONE);
    assign done           = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = CHAIN_RST;
            CHAIN_RST: begin
                if (abort)                          state_d = IDLE;
                else if (rst_cnt_q == RLEN - 8'd1)  state_d = SHIFT;
            end
            SHIFT: begin
                if (abort)           state_d = IDLE;
                else if (last_shift) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= IDLE;
            rst_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            acc_cnt_q  <= '0;
            wreg_q     <= '0;
            wcnt_q     <= '0;
            rst_flag_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_flag_q <= 1'b0;
            if (start_ok) begin
                rst_cnt_q <= '0;
                bit_cnt_q <= '0;
                acc_cnt_q <= '0;
                wcnt_q    <= '0;
            end else if (busy && abort) begin
                wcnt_q <= '0;
                wreg_q <= '0;
            end else if (state_q == CHAIN_RST) begin
                rst_cnt_q <= rst_cnt_q + 8'd1;
            end else if (state_q == SHIFT) begin
                if (shifting) bit_cnt_q <= bit_cnt_q + 16'd1;
                if (load) begin
                    wreg_q    <= cfg_data;
                    wcnt_q    <= load_bits;
                    acc_cnt_q <= acc_cnt_q + {10'd0, load_bits};
                end else if (shifting) begin
                    wcnt_q <= wcnt_q - 6'd1;
                    // keep the final bit parked so the head line holds during stalls
                    if (wcnt_q > 6'd1) wreg_q <= {1'b0, wreg_q[31:1]};
                end
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [31:0] rb_word_q, rb_data_q, rb_capture;
    logic [4:0]  rb_k_q;
    logic        rb_valid_q;

    assign rb_capture = rb_word_q | (32'(ccff_tail_in) << rb_k_q);
    assign rb_data    = rb_data_q;
    assign rb_valid   = rb_valid_q;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rb_word_q  <= '0;
            rb_data_q  <= '0;
            rb_k_q     <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (start_ok || (busy && abort)) begin
                rb_word_q <= '0;
                rb_k_q    <= '0;
            end else if (shifting) begin
                if ((rb_k_q == 5'd31) || last_shift) begin
                    rb_data_q  <= rb_capture;
                    rb_valid_q <= 1'b1;
                    rb_word_q  <= '0;
                    rb_k_q     <= '0;
                end else begin
                    rb_word_q <= rb_capture;
                    rb_k_q    <= rb_k_q + 5'd1;
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail_in;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif
endmodule
